pulse_width_meter: RTL and testbench
====================================

// Module: pulse_width_meter
// PURPOSE
//  Measures the high time of an external pulse in clock cycles; receive-side counterpart of the
//  timed monoflop. Synchronizes an asynchronous input, counts its high duration, and publishes
//  the result with a valid/ack handshake. Used to check pulse lengths on input lines and to
//  loop back monoflop outputs for self-test.
// PARAMETERS
//  WidthBits   16  counter / result width; max measurable length 2^WidthBits-1 cycles
//  SyncStages   2  synchronizer flops on pulse_in (>=2)
//  MinPulse     1  pulses with synchronized high time < MinPulse cycles are discarded (1..2^WidthBits-1)
// PORTS
//  clock     in   1          system clock; all logic on posedge
//  reset     in   1          asynchronous, active-high; clears all state
//  enable    in   1          arms measurement; deassert aborts a measurement in progress
//  pulse_in  in   1          asynchronous pulse to be measured
//  ack       in   1          consumer acknowledges current result
//  width     out  WidthBits  measured high time, cycles (saturating)
//  overflow  out  1          result saturated (true length > 2^WidthBits-1)
//  valid     out  1          width/overflow hold an unacknowledged result
//  busy      out  1          state != IDLE
//  dropped   out  1          one-cycle strobe: completed pulse lost because valid was pending
// BEHAVIOUR
//  Reset: sync chain, prev-sample, counter = 0; state IDLE; width=0, overflow=0, valid=0, dropped=0.
//  s = last synchronizer stage; p = s delayed one cycle (always updated, also when disabled).
//  Rising edge = s & ~p. Input already high when enable rises is NOT measured (no edge).
//  FSM:
//   IDLE:     enable & rising edge -> MEASURE, count<=1, ovf<=0.
//   MEASURE:  ~enable -> WAIT_LOW (abort, no result, no dropped).
//             s==1 -> count<=count+1; at all-ones count holds and ovf<=1.
//             s==0 -> IDLE; if count>=MinPulse publish, else discard silently.
//   WAIT_LOW: s==0 -> IDLE. Ignores enable.
//  Width rule: N consecutive cycles of s high -> width=N (monoflop pulselength N on same clock -> N).
//  Publish (edge where MEASURE samples s==0):
//   valid==0, or valid==1 & ack==1 same edge -> width<=count, overflow<=ovf, valid<=1.
//   valid==1 & ack==0 -> width/overflow unchanged, dropped=1 for exactly one cycle.
//  Handshake: valid clears on edge with ack=1 & valid=1 and no publish; ack with valid=0 ignored.
//   width/overflow hold last value after ack until next publish.
//  Latency: valid rises at the edge sampling s low, i.e. <= SyncStages+1 cycles after pulse_in falls.
//  Back-to-back: pulse may restart the cycle after MEASURE->IDLE; a new edge while in IDLE is taken
//   immediately; minimum low gap between measured pulses = 1 synchronized cycle.
//  Reset mid-operation: immediate return to reset values; pulse in progress is lost; following
//   pulse measured normally only after a fresh rising edge.
//  busy is combinational from state (MEASURE or WAIT_LOW).
// TESTING
//  1 enable=1, 5-cycle pulse, ack 3 cycles after valid -> width=5, overflow=0, valid high until ack edge.
//  2 WidthBits=4, 20-cycle pulse -> width=15, overflow=1; next 6-cycle pulse after ack -> width=6, overflow=0.
//  3 MinPulse=3: 2-cycle pulse -> no valid, busy 2 cycles; 3-cycle pulse -> width=3, valid=1.
//  4 pulses 4 then 7, no ack -> width=4 kept, dropped 1 cycle at end of 2nd; third pulse 6 ending on
//    an ack edge -> width=6, valid stays 1.
//  5 enable low at count 3 -> no valid, busy until pulse_in low; pulse_in high before enable rises
//    -> not measured, busy=0.
//  6 reset during 10-cycle pulse -> all outputs 0 at once; next 8-cycle pulse -> width=8.

Source files
------------

// File: rtl/pulse_width_meter.sv
// Pulse width meter: synchronizes pulse_in, counts its synchronized high time in clock
// cycles and offers the saturating result to a consumer through a valid/ack handshake.
module pulse_width_meter #(
    parameter int WidthBits  = 16,
    parameter int SyncStages = 2,
    parameter int MinPulse   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pulse_in,
    input  logic                 ack,
    output logic [WidthBits-1:0] width,
    output logic                 overflow,
    output logic                 valid,
    output logic                 busy,
    output logic                 dropped
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MEASURE  = 2'b01,
        WAIT_LOW = 2'b10
    } state_t;

    localparam logic [WidthBits-1:0] MinCount = WidthBits'(MinPulse);
    localparam logic [WidthBits-1:0] CountOne = {{(WidthBits-1){1'b0}}, 1'b1};

    state_t                 state_r;
    logic [SyncStages-1:0]  sync_r;
    logic                   prev_r;
    logic [WidthBits-1:0]   count_r;
    logic                   ovf_r;
    logic                   sync_s;
    logic                   rise_s;
    logic                   count_max_s;

    assign sync_s      = sync_r[SyncStages-1];
    assign rise_s      = sync_s & ~prev_r;
    assign count_max_s = (count_r == {WidthBits{1'b1}});
    assign busy        = (state_r != IDLE);

    // Synchronizer chain plus delayed sample; runs regardless of enable so edges stay honest
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r <= {SyncStages{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SyncStages-2:0], pulse_in};
            prev_r <= sync_s;
        end
    end

    // Measurement FSM with registered result and handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            count_r  <= {WidthBits{1'b0}};
            ovf_r    <= 1'b0;
            width    <= {WidthBits{1'b0}};
            overflow <= 1'b0;
            valid    <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            dropped <= 1'b0;
            // A publish below overrides this clear when both land on the same edge
            if (valid && ack) begin
                valid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (enable && rise_s) begin
                        state_r <= MEASURE;
                        count_r <= CountOne;
                        ovf_r   <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        state_r <= WAIT_LOW;
                    end else if (sync_s) begin
                        if (count_max_s) begin
                            ovf_r <= 1'b1;
                        end else begin
                            count_r <= count_r + CountOne;
                        end
                    end else begin
                        state_r <= IDLE;
                        if (count_r >= MinCount) begin
                            if (!valid || ack) begin
                                width    <= count_r;
                                overflow <= ovf_r;
                                valid    <= 1'b1;
                            end else begin
                                dropped <= 1'b1;
                            end
                        end
                    end
                end
                WAIT_LOW: begin
                    if (!sync_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: a per-cycle vector table, directed corner sequences and a
// randomized pulse train checked against a pulse-level reference model.
module tb_pulse_width_meter;

    localparam int W    = 4;
    localparam int SYNC = 2;
    localparam int MINP = 3;
    localparam int MAXW = (1 << W) - 1;

    logic         clock;
    logic         reset;
    logic         enable;
    logic         pulse_in;
    logic         ack;
    logic [W-1:0] width;
    logic         overflow;
    logic         valid;
    logic         busy;
    logic         dropped;

    int total;
    int bad;
    int busy_cnt;
    int drop_cnt;

    // reference model state for the random phase
    bit hist[$];
    int m_valid;
    int m_width;
    int m_ovf;

    typedef struct {
        logic p;
        logic e;
        logic a;
        int   v;
        int   w;
        int   o;
        int   b;
        int   d;
    } vec_t;

    vec_t tv[12];

    pulse_width_meter #(
        .WidthBits (W),
        .SyncStages(SYNC),
        .MinPulse  (MINP)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .pulse_in(pulse_in),
        .ack     (ack),
        .width   (width),
        .overflow(overflow),
        .valid   (valid),
        .busy    (busy),
        .dropped (dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic e, input logic a, input int n);
        for (int i = 0; i < n; i++) begin
            pulse_in = p;
            enable   = e;
            ack      = a;
            @(posedge clock);
            #1;
            busy_cnt += int'(busy);
            drop_cnt += int'(dropped);
        end
    endtask

    // one random-phase cycle: drive, then compare against the pulse-level model
    task automatic rand_step(input bit p, input bit a);
        int j;
        int s_now;
        int s_old;
        int len;
        int k;
        int exp_drop;
        hist.push_back(p);
        drive(p, 1'b1, a, 1);
        j        = hist.size() - 1;
        s_now    = (j >= SYNC) ? int'(hist[j-SYNC]) : 0;
        s_old    = (j - 1 >= SYNC) ? int'(hist[j-1-SYNC]) : 0;
        exp_drop = 0;
        len      = 0;
        if (s_now == 0 && s_old == 1) begin
            k = j - 1;
            while (k >= SYNC && hist[k-SYNC]) begin
                len++;
                k--;
            end
        end
        if (len >= MINP) begin
            if (m_valid == 0 || a) begin
                m_width = (len > MAXW) ? MAXW : len;
                m_ovf   = (len > MAXW) ? 1 : 0;
                m_valid = 1;
            end else begin
                exp_drop = 1;
            end
        end else if (m_valid == 1 && a) begin
            m_valid = 0;
        end
        check("rnd_valid", int'(valid), m_valid);
        check("rnd_width", int'(width), m_width);
        check("rnd_overflow", int'(overflow), m_ovf);
        check("rnd_dropped", int'(dropped), exp_drop);
        check("rnd_busy", int'(busy), s_now);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        busy_cnt = 0;
        drop_cnt = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        pulse_in = 1'b0;
        ack      = 1'b0;

        // 5-cycle pulse, ack three cycles after valid
        tv[0]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        tv[1]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        tv[2]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 0};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 0};
        tv[4]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 1, 5, 0, 0, 0};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 1, 5, 0, 0, 0};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 1, 5, 0, 0, 0};
        tv[10] = '{1'b0, 1'b1, 1'b1, 0, 5, 0, 0, 0};
        tv[11] = '{1'b0, 1'b1, 1'b0, 0, 5, 0, 0, 0};

        repeat (2) @(posedge clock);
        #1;
        check("reset_width", int'(width), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_dropped", int'(dropped), 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tv[i].p, tv[i].e, tv[i].a, 1);
            check($sformatf("t1_valid[%0d]", i), int'(valid), tv[i].v);
            check($sformatf("t1_width[%0d]", i), int'(width), tv[i].w);
            check($sformatf("t1_ovf[%0d]", i), int'(overflow), tv[i].o);
            check($sformatf("t1_busy[%0d]", i), int'(busy), tv[i].b);
            check($sformatf("t1_drop[%0d]", i), int'(dropped), tv[i].d);
        end

        // saturation, then a normal pulse after ack
        drive(1'b1, 1'b1, 1'b0, 20);
        drive(1'b0, 1'b1, 1'b0, 4);
        check("t2_sat_width", int'(width), 15);
        check("t2_sat_ovf", int'(overflow), 1);
        check("t2_sat_valid", int'(valid), 1);
        drive(1'b0, 1'b1, 1'b1, 1);
        check("t2_ack_valid", int'(valid), 0);
        check("t2_hold_width", int'(width), 15);
        drive(1'b1, 1'b1, 1'b0, 6);
        drive(1'b0, 1'b1, 1'b0, 4);
        check("t2_width6", int'(width), 6);
        check("t2_ovf6", int'(overflow), 0);
        check("t2_valid6", int'(valid), 1);
        drive(1'b0, 1'b1, 1'b1, 1);

        // short pulse below MinPulse is discarded, exact MinPulse is kept
        busy_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 2);
        drive(1'b0, 1'b1, 1'b0, 4);
        check("t3_short_busy", busy_cnt, 2);
        check("t3_short_valid", int'(valid), 0);
        check("t3_short_width", int'(width), 6);
        drive(1'b1, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b0, 4);
        check("t3_min_width", int'(width), 3);
        check("t3_min_valid", int'(valid), 1);
        drive(1'b0, 1'b1, 1'b1, 1);

        // pending result: second pulse dropped, third published on the ack edge
        drive(1'b1, 1'b1, 1'b0, 4);
        drive(1'b0, 1'b1, 1'b0, 4);
        check("t4_first_width", int'(width), 4);
        drop_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 7);
        drive(1'b0, 1'b1, 1'b0, 4);
        check("t4_drop_count", drop_cnt, 1);
        check("t4_kept_width", int'(width), 4);
        check("t4_kept_valid", int'(valid), 1);
        drop_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 6);
        drive(1'b0, 1'b1, 1'b0, 2);
        drive(1'b0, 1'b1, 1'b1, 1);
        check("t4_ackpub_width", int'(width), 6);
        check("t4_ackpub_valid", int'(valid), 1);
        check("t4_ackpub_drop", drop_cnt, 0);
        drive(1'b0, 1'b1, 1'b1, 1);
        check("t4_final_valid", int'(valid), 0);

        // abort by enable low at count 3, then input already high when enabled
        busy_cnt = 0;
        drive(1'b1, 1'b1, 1'b0, 5);
        drive(1'b1, 1'b0, 1'b0, 5);
        drive(1'b0, 1'b0, 1'b0, 2);
        check("t5_busy_tail", int'(busy), 1);
        drive(1'b0, 1'b0, 1'b0, 1);
        check("t5_busy_end", int'(busy), 0);
        check("t5_busy_count", busy_cnt, 10);
        check("t5_abort_valid", int'(valid), 0);
        busy_cnt = 0;
        drive(1'b1, 1'b0, 1'b0, 4);
        drive(1'b1, 1'b1, 1'b0, 6);
        check("t5_prehigh_busy", busy_cnt, 0);
        drive(1'b0, 1'b1, 1'b0, 4);
        check("t5_prehigh_valid", int'(valid), 0);

        // reset in the middle of a measurement with a result pending
        drive(1'b1, 1'b1, 1'b0, 5);
        drive(1'b0, 1'b1, 1'b0, 4);
        check("t6_pre_valid", int'(valid), 1);
        drive(1'b1, 1'b1, 1'b0, 5);
        reset    = 1'b1;
        pulse_in = 1'b0;
        #1;
        check("t6_rst_width", int'(width), 0);
        check("t6_rst_valid", int'(valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_ovf", int'(overflow), 0);
        check("t6_rst_drop", int'(dropped), 0);
        drive(1'b0, 1'b1, 1'b0, 2);
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 2);
        drive(1'b1, 1'b1, 1'b0, 8);
        drive(1'b0, 1'b1, 1'b0, 4);
        check("t6_after_width", int'(width), 8);
        check("t6_after_valid", int'(valid), 1);
        check("t6_after_ovf", int'(overflow), 0);

        // randomized pulse train from a clean reset
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1);
        reset   = 1'b0;
        m_valid = 0;
        m_width = 0;
        m_ovf   = 0;
        for (int k = 0; k < 40; k++) begin
            int len;
            int gap;
            len = int'($urandom_range(1, 20));
            gap = int'($urandom_range(1, 5));
            for (int i = 0; i < len + gap; i++) begin
                rand_step(i < len, $urandom_range(0, 3) == 0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            rand_step(1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
